updown_seq_ctrl: RTL and testbench

Sequencer for the bounded up/down counter datapath.
- Accepts a one-cycle start command carrying a mode, a window [lo,hi] and a pass count.
- Steps the count through the window (up, down or ping-pong), with pause and abort controls.
- Reports busy/done/err to the surrounding control logic.
- Sits between the mini-project top-level FSM and the counter/flip-flop datapath.

---
 rtl/updown_seq_pkg.sv | 28 ++
 rtl/updown_cnt_core.sv | 41 ++++
 rtl/updown_seq_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_updown_seq_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/updown_seq_pkg.sv
// -----------------------------------------------------------------------------
// updown_seq_pkg
// Shared encodings for the up/down counter sequencer.
//   mode_e   : command mode carried with a start strobe
//   state_e  : sequencer FSM states
//   sweeps_eff() : maps a pass count of 0 onto 1
// -----------------------------------------------------------------------------
package updown_seq_pkg;

    typedef enum logic [1:0] {
        MODE_UP       = 2'd0,
        MODE_DOWN     = 2'd1,
        MODE_PINGPONG = 2'd2,
        MODE_WRAP     = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    // A request for zero passes still performs one end-to-end pass.
    function automatic int unsigned sweeps_eff(input int unsigned sweeps);
        return (sweeps == 0) ? 1 : sweeps;
    endfunction

endpackage : updown_seq_pkg

// File: rtl/updown_cnt_core.sv
// -----------------------------------------------------------------------------
// updown_cnt_core
// WIDTH-bit loadable up/down counter register; load has priority over en.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset (count -> 0)
//   load     in   load load_val this cycle
//   load_val in   value to load
//   en       in   step by one this cycle (ignored while load is high)
//   dir      in   step direction: 1 = +1, 0 = -1
//   count    out  registered counter value
// -----------------------------------------------------------------------------
module updown_cnt_core #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    // NOTE: sequential state is assigned with <= so every register samples
    // the values present before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en) begin
            count_q <= dir ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule : updown_cnt_core

// File: rtl/updown_seq_ctrl.sv
// -----------------------------------------------------------------------------
// updown_seq_ctrl
// Sequencer that steps a bounded counter through [lo,hi] in UP, DOWN or
// PINGPONG mode, with level-sensitive pause (hold) and abort (stop).
// Optional build macro UPDOWN_SEQ_WRAP_EN: when defined, mode 3 is WRAP
// (lo..hi then back to lo, until stop); when undefined, mode 3 is rejected
// with an err pulse.
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   start      command strobe, sampled only in IDLE
//   mode       command mode (see mode_e), sampled with start
//   lo, hi     inclusive window bounds, sampled with start
//   sweeps     PINGPONG pass count (0 means 1), sampled with start
//   hold       pause request (level)
//   stop       abort request (level)
//   count      current counter value
//   up_down    current direction, 1 = up
//   busy       high in RUN and PAUSE
//   done       one-cycle pulse on normal completion
//   err        one-cycle pulse on a rejected command
// All outputs are registered.
// -----------------------------------------------------------------------------
module updown_seq_ctrl
    import updown_seq_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int PASS_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [WIDTH-1:0]  lo,
    input  logic [WIDTH-1:0]  hi,
    input  logic [PASS_W-1:0] sweeps,
    input  logic              hold,
    input  logic              stop,
    output logic [WIDTH-1:0]  count,
    output logic              up_down,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [WIDTH-1:0]  lo_q, lo_d, hi_q, hi_d;
    logic [PASS_W-1:0] sweeps_q, sweeps_d, pass_q, pass_d;
    logic              up_down_q, up_down_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic              cnt_load, cnt_en, cnt_dir;
    logic [WIDTH-1:0]  cnt_load_val;
    logic              at_lo, at_hi, mode_reject;

    updown_cnt_core #(.WIDTH(WIDTH)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .dir      (cnt_dir),
        .count    (count)
    );

    assign at_lo = (count == lo_q);
    assign at_hi = (count == hi_q);

`ifdef UPDOWN_SEQ_WRAP_EN
    assign mode_reject = 1'b0;
`else
    assign mode_reject = (mode == MODE_WRAP);
`endif

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statements can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        sweeps_d     = sweeps_q;
        pass_d       = pass_q;
        up_down_d    = up_down_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = lo_q;
        cnt_en       = 1'b0;
        cnt_dir      = up_down_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if ((lo > hi) || mode_reject) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d       = mode_e'(mode);
                        lo_d         = lo;
                        hi_d         = hi;
                        sweeps_d     = PASS_W'(sweeps_eff(32'(sweeps)));
                        pass_d       = '0;
                        cnt_load     = 1'b1;
                        cnt_load_val = (mode == MODE_DOWN) ? hi : lo;
                        up_down_d    = (mode != MODE_DOWN);
                        busy_d       = 1'b1;
                        state_d      = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (hold) begin
                    state_d = ST_PAUSE;
                end else begin
                    unique case (mode_q)
                        MODE_UP: begin
                            if (at_hi) begin
                                state_d = ST_IDLE;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end else begin
                                cnt_en  = 1'b1;
                                cnt_dir = 1'b1;
                            end
                        end
                        MODE_DOWN: begin
                            if (at_lo) begin
                                state_d = ST_IDLE;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end else begin
                                cnt_en  = 1'b1;
                                cnt_dir = 1'b0;
                            end
                        end
                        MODE_PINGPONG: begin
                            if (up_down_q ? at_hi : at_lo) begin
                                pass_d = pass_q + PASS_W'(1);
                                if (pass_d == sweeps_q) begin
                                    state_d = ST_IDLE;
                                    busy_d  = 1'b0;
                                    done_d  = 1'b1;
                                end else begin
                                    // Turn around without dwelling; a
                                    // single-value window cannot move at all.
                                    up_down_d = ~up_down_q;
                                    cnt_en    = (lo_q != hi_q);
                                    cnt_dir   = ~up_down_q;
                                end
                            end else begin
                                cnt_en = 1'b1;
                            end
                        end
`ifdef UPDOWN_SEQ_WRAP_EN
                        MODE_WRAP: begin
                            if (at_hi) begin
                                cnt_load = 1'b1;
                            end else begin
                                cnt_en  = 1'b1;
                                cnt_dir = 1'b1;
                            end
                        end
`endif
                        default: begin
                            // Only reachable if an unsupported mode was latched.
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end
                    endcase
                end
            end

            ST_PAUSE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (!hold) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_UP;
            lo_q      <= '0;
            hi_q      <= '0;
            sweeps_q  <= '0;
            pass_q    <= '0;
            up_down_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            sweeps_q  <= sweeps_d;
            pass_q    <= pass_d;
            up_down_q <= up_down_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign up_down = up_down_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule : updown_seq_ctrl

// File: tb/tb_updown_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_updown_seq_ctrl
// Self-checking bench for updown_seq_ctrl. Each cycle's expected outputs are
// pushed to a scoreboard queue as the stimulus for that edge is applied, then
// popped and compared shortly after the edge.
// Optional build macro UPDOWN_SEQ_WRAP_EN selects the WRAP-mode expectations.
// -----------------------------------------------------------------------------
module tb_updown_seq_ctrl;

    typedef struct packed {
        logic [2:0] count;
        logic       up_down;
        logic       busy;
        logic       done;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, start, hold, stop;
    logic [1:0] mode;
    logic [2:0] lo, hi, count;
    logic [3:0] sweeps;
    logic       up_down, busy, done, err;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    updown_seq_ctrl #(.WIDTH(3), .PASS_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mode    (mode),
        .lo      (lo),
        .hi      (hi),
        .sweeps  (sweeps),
        .hold    (hold),
        .stop    (stop),
        .count   (count),
        .up_down (up_down),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Push the expected post-edge outputs, advance one edge, pop and compare.
    task automatic tick(input string tag, input logic [2:0] c,
                        input logic ud, input logic b, input logic d, input logic e);
        exp_t x;
        sb_q.push_back('{count: c, up_down: ud, busy: b, done: d, err: e});
        @(posedge clk);
        #1;
        x = sb_q.pop_front();
        check({tag, ".count"}, 32'(count), 32'(x.count));
        check({tag, ".ud_busy_done_err"}, 32'({up_down, busy, done, err}),
              32'({x.up_down, x.busy, x.done, x.err}));
    endtask

    task automatic cmd(input logic [1:0] m, input logic [2:0] l, input logic [2:0] h,
                       input logic [3:0] s);
        start  = 1'b1;
        mode   = m;
        lo     = l;
        hi     = h;
        sweeps = s;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 2'd0; lo = '0; hi = '0;
        sweeps = '0; hold = 1'b0; stop = 1'b0;

        tick("reset", 0, 1, 0, 0, 0);
        rst = 1'b0;
        tick("idle", 0, 1, 0, 0, 0);
        hold = 1'b1; stop = 1'b1;
        tick("idle_ignores_ctl", 0, 1, 0, 0, 0);
        hold = 1'b0; stop = 1'b0;

        // UP 2..5
        cmd(2'd0, 3'd2, 3'd5, 4'd0);
        tick("up_load", 2, 1, 1, 0, 0);
        start = 1'b0;
        for (int v = 3; v <= 5; v++) tick("up_step", 3'(v), 1, 1, 0, 0);
        tick("up_done", 5, 1, 0, 1, 0);
        tick("up_after", 5, 1, 0, 0, 0);

        // PINGPONG 1..3, two passes
        cmd(2'd2, 3'd1, 3'd3, 4'd2);
        tick("pp_load", 1, 1, 1, 0, 0);
        start = 1'b0;
        tick("pp_up", 2, 1, 1, 0, 0);
        tick("pp_top", 3, 1, 1, 0, 0);
        tick("pp_flip", 2, 0, 1, 0, 0);
        tick("pp_down", 1, 0, 1, 0, 0);
        tick("pp_done", 1, 0, 0, 1, 0);

        // Pause at 3 for three cycles, then resume to 7
        cmd(2'd0, 3'd0, 3'd7, 4'd0);
        tick("pause_load", 0, 1, 1, 0, 0);
        start = 1'b0;
        for (int v = 1; v <= 3; v++) tick("pause_pre", 3'(v), 1, 1, 0, 0);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) tick("pause_hold", 3, 1, 1, 0, 0);
        hold = 1'b0;
        tick("pause_resume", 3, 1, 1, 0, 0);
        for (int v = 4; v <= 7; v++) tick("pause_post", 3'(v), 1, 1, 0, 0);
        tick("pause_done", 7, 1, 0, 1, 0);

        // Abort DOWN at 4
        cmd(2'd1, 3'd0, 3'd6, 4'd0);
        tick("abort_load", 6, 0, 1, 0, 0);
        start = 1'b0;
        tick("abort_step", 5, 0, 1, 0, 0);
        tick("abort_step", 4, 0, 1, 0, 0);
        stop = 1'b1;
        tick("abort_stop", 4, 0, 0, 0, 0);
        stop = 1'b0;
        tick("abort_idle", 4, 0, 0, 0, 0);

        // New command after abort: lo == hi in UP finishes after one RUN cycle
        cmd(2'd0, 3'd4, 3'd4, 4'd0);
        tick("lohi_up_load", 4, 1, 1, 0, 0);
        start = 1'b0;
        tick("lohi_up_done", 4, 1, 0, 1, 0);

        // Rejected window lo > hi
        cmd(2'd0, 3'd5, 3'd2, 4'd0);
        tick("rej_window", 4, 1, 0, 0, 1);
        start = 1'b0;
        tick("rej_window_after", 4, 1, 0, 0, 0);

        // Mode 3
        cmd(2'd3, 3'd6, 3'd7, 4'd0);
`ifdef UPDOWN_SEQ_WRAP_EN
        tick("wrap_load", 6, 1, 1, 0, 0);
        start = 1'b0;
        tick("wrap", 7, 1, 1, 0, 0);
        tick("wrap_back", 6, 1, 1, 0, 0);
        tick("wrap", 7, 1, 1, 0, 0);
        stop = 1'b1;
        tick("wrap_stop", 7, 1, 0, 0, 0);
        stop = 1'b0;
        tick("wrap_idle", 7, 1, 0, 0, 0);
`else
        tick("rej_mode3", 4, 1, 0, 0, 1);
        start = 1'b0;
        tick("rej_mode3_after", 4, 1, 0, 0, 0);
`endif

        // start beats stop in IDLE; start while busy is ignored
        cmd(2'd0, 3'd1, 3'd3, 4'd0);
        stop = 1'b1;
        tick("start_over_stop", 1, 1, 1, 0, 0);
        stop = 1'b0;
        cmd(2'd1, 3'd7, 3'd7, 4'd0);
        tick("start_busy_ignored", 2, 1, 1, 0, 0);
        start = 1'b0;
        tick("busy_step", 3, 1, 1, 0, 0);
        tick("busy_done", 3, 1, 0, 1, 0);

        // PINGPONG with sweeps = 0 behaves as one pass
        cmd(2'd2, 3'd2, 3'd3, 4'd0);
        tick("pp0_load", 2, 1, 1, 0, 0);
        start = 1'b0;
        tick("pp0_top", 3, 1, 1, 0, 0);
        tick("pp0_done", 3, 1, 0, 1, 0);

        // PINGPONG with lo == hi: one pass per RUN cycle, no movement
        cmd(2'd2, 3'd5, 3'd5, 4'd3);
        tick("pp_lohi_load", 5, 1, 1, 0, 0);
        start = 1'b0;
        tick("pp_lohi_pass1", 5, 0, 1, 0, 0);
        tick("pp_lohi_pass2", 5, 1, 1, 0, 0);
        tick("pp_lohi_done", 5, 1, 0, 1, 0);

        // stop while paused: no done
        cmd(2'd0, 3'd0, 3'd7, 4'd0);
        tick("pstop_load", 0, 1, 1, 0, 0);
        start = 1'b0;
        hold  = 1'b1;
        tick("pstop_pause", 0, 1, 1, 0, 0);
        stop = 1'b1;
        tick("pstop_stop", 0, 1, 0, 0, 0);
        hold = 1'b0; stop = 1'b0;

        // Reset mid-PINGPONG wins over hold and stop
        cmd(2'd2, 3'd0, 3'd7, 4'd3);
        tick("rst_load", 0, 1, 1, 0, 0);
        start = 1'b0;
        tick("rst_step", 1, 1, 1, 0, 0);
        tick("rst_step", 2, 1, 1, 0, 0);
        rst = 1'b1; hold = 1'b1; stop = 1'b1;
        tick("rst_mid_run", 0, 1, 0, 0, 0);
        rst = 1'b0; hold = 1'b0; stop = 1'b0;
        tick("rst_idle", 0, 1, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_updown_seq_ctrl
